// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: groups the core-side sequencing signals of pipe_ctrl.
// The master modport is the core (drives requests); slave is the controller.
interface pipe_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 32
);
  localparam int SW = $clog2(NSTAGE);

  logic              in_valid;
  logic [NSTAGE-1:0] stage_busy;
  logic              redirect_req;
  logic [SW-1:0]     redirect_stage;
  logic [PC_W-1:0]   redirect_pc;
  logic              trap_req;
  logic [PC_W-1:0]   trap_pc;
  logic              bus_busy;

  logic [NSTAGE-1:0] stage_valid;
  logic [NSTAGE-1:0] stage_en;
  logic [NSTAGE-1:0] stage_bubble;
  logic              flush_all;
  logic              pc_redir_valid;
  logic [PC_W-1:0]   pc_redir;
  logic              trap_pending;
  logic [CNT_W-1:0]  perf_cycles;
  logic [CNT_W-1:0]  perf_stalls;
  logic [CNT_W-1:0]  perf_flushes;

  modport master (
    output in_valid, stage_busy, redirect_req, redirect_stage, redirect_pc,
           trap_req, trap_pc, bus_busy,
    input  stage_valid, stage_en, stage_bubble, flush_all, pc_redir_valid,
           pc_redir, trap_pending, perf_cycles, perf_stalls, perf_flushes
  );

  modport slave (
    input  in_valid, stage_busy, redirect_req, redirect_stage, redirect_pc,
           trap_req, trap_pc, bus_busy,
    output stage_valid, stage_en, stage_bubble, flush_all, pc_redir_valid,
           pc_redir, trap_pending, perf_cycles, perf_stalls, perf_flushes
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage valid/stall/bubble sequencing, branch redirect kill and drain-then-flush trap FSM.
// Define PIPE_PERF_CNT_EN to build the saturating cycle/stall/flush counters; otherwise they read zero.
module pipe_ctrl #(
  parameter int NSTAGE = 5,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 32
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave ctl
);
  localparam int SW = $clog2(NSTAGE);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [NSTAGE-1:1] valid_q, valid_d;
  logic              redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]   redir_pc_q, redir_pc_d;

  logic              frozen;
  logic              flush_now;
  logic              stall_k;
  logic              redir_acc;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] bubble;
  logic [NSTAGE-1:0] v_all;
  logic [NSTAGE-1:1] kill;

  // A pending trap or any non-idle trap state freezes the whole pipe.
  assign frozen              = ctl.trap_req | (state_q != ST_IDLE);
  assign stall[NSTAGE-1]     = ctl.stage_busy[NSTAGE-1] | frozen;
  assign v_all[0]            = ctl.in_valid;
  assign bubble[0]           = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE - 1; gi++) begin : g_stall
      assign stall[gi] = ctl.stage_busy[gi] | stall[gi+1];
    end

    for (gi = 1; gi < NSTAGE; gi++) begin : g_stage
      assign kill[gi]    = redir_acc & (SW'(gi) <= ctl.redirect_stage);
      assign bubble[gi]  = stall[gi-1] | kill[gi];
      assign v_all[gi]   = valid_q[gi];
      assign valid_d[gi] = flush_now  ? 1'b0 :
                           ~stall[gi] ? (v_all[gi-1] & ~bubble[gi]) :
                                        valid_q[gi];
    end
  endgenerate

  // An out-of-range redirect stage reads as stalled and is never accepted.
  always_comb begin
    stall_k = 1'b1;
    for (int i = 0; i < NSTAGE; i++) begin
      if (ctl.redirect_stage == SW'(i)) stall_k = stall[i];
    end
  end

  assign redir_acc = ctl.redirect_req & ~stall_k & ~frozen;

  always_comb begin
    state_d   = state_q;
    flush_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctl.trap_req) state_d = ctl.bus_busy ? ST_DRAIN : ST_FLUSH;
      end
      ST_DRAIN: begin
        if (!ctl.bus_busy) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_now = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign redir_valid_d = redir_acc | flush_now;
  assign redir_pc_d    = flush_now ? ctl.trap_pc :
                         redir_acc ? ctl.redirect_pc : redir_pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      valid_q       <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign ctl.stage_valid    = v_all;
  assign ctl.stage_en       = ~stall;
  assign ctl.stage_bubble   = bubble;
  assign ctl.flush_all      = flush_now;
  assign ctl.pc_redir_valid = redir_valid_q;
  assign ctl.pc_redir       = redir_pc_q;
  assign ctl.trap_pending   = frozen;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stl_q, stl_d;
  logic [CNT_W-1:0] fls_q, fls_d;

  // All three counters stick at all-ones rather than wrapping.
  assign cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
  assign stl_d = (stall[0] && !(&stl_q)) ? stl_q + CNT_W'(1) : stl_q;
  assign fls_d = ((redir_acc || flush_now) && !(&fls_q)) ? fls_q + CNT_W'(1) : fls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      stl_q <= '0;
      fls_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      stl_q <= stl_d;
      fls_q <= fls_d;
    end
  end

  assign ctl.perf_cycles  = cyc_q;
  assign ctl.perf_stalls  = stl_q;
  assign ctl.perf_flushes = fls_q;
`else
  assign ctl.perf_cycles  = {CNT_W{1'b0}};
  assign ctl.perf_stalls  = {CNT_W{1'b0}};
  assign ctl.perf_flushes = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table, reset/perf sequences and a randomized run
// checked against a cycle-level model of the sequencing rules.
module tb_pipe_ctrl;
  localparam int NS = 5;
  localparam int PW = 64;
  localparam int CW = 32;
  localparam int SW = $clog2(NS);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.NSTAGE(NS), .PC_W(PW), .CNT_W(CW)) ctl ();

  pipe_ctrl #(.NSTAGE(NS), .PC_W(PW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [4:0]  busy;
    logic        rr;
    logic [2:0]  rs;
    logic [63:0] rpc;
    logic        tr;
    logic [63:0] tpc;
    logic        bb;
    logic [4:0]  e_valid;
    logic [4:0]  e_en;
    logic [4:0]  e_bub;
    logic        e_flush;
    logic        e_prv;
    logic [63:0] e_pcr;
    logic        e_pend;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] busy, input logic rr, input logic [2:0] rs,
                              input logic [63:0] rpc, input logic tr, input logic [63:0] tpc,
                              input logic bb, input logic [4:0] ev, input logic [4:0] ee,
                              input logic [4:0] eb, input logic ef, input logic ep,
                              input logic [63:0] epc, input logic epend);
    vec_t v;
    v.busy = busy; v.rr = rr; v.rs = rs; v.rpc = rpc; v.tr = tr; v.tpc = tpc; v.bb = bb;
    v.e_valid = ev; v.e_en = ee; v.e_bub = eb; v.e_flush = ef; v.e_prv = ep;
    v.e_pcr = epc; v.e_pend = epend;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [4:0] busy, input logic rr,
                       input logic [2:0] rs, input logic [63:0] rpc, input logic tr,
                       input logic [63:0] tpc, input logic bb);
    ctl.in_valid       = iv;
    ctl.stage_busy     = busy;
    ctl.redirect_req   = rr;
    ctl.redirect_stage = rs;
    ctl.redirect_pc    = rpc;
    ctl.trap_req       = tr;
    ctl.trap_pc        = tpc;
    ctl.bus_busy       = bb;
  endtask

  // Reference model state
  bit          mv[NS];
  int          phase;        // 0 idle, 1 draining, 2 flushing
  logic        m_prv;
  logic [63:0] m_pcr;
  longint      mc, ms, mf;
  bit          last_acc, last_fl;

  function automatic longint sat_inc(input longint x);
    longint lim = (64'd1 << CW) - 1;
    return (x >= lim) ? lim : x + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mv[i] = 1'b0;
    phase = 0; m_prv = 1'b0; m_pcr = '0; mc = 0; ms = 0; mf = 0;
    last_acc = 1'b0; last_fl = 1'b0;
  endtask

  task automatic model_step();
    bit st[NS];
    bit bub[NS];
    bit frozen, acc, fl;
    int k;
    logic [4:0] ev, ee, eb;
    frozen = ctl.trap_req || (phase != 0);
    for (int i = 0; i < NS; i++) begin
      st[i] = frozen;
      for (int j = i; j < NS; j++) if (ctl.stage_busy[j]) st[i] = 1'b1;
    end
    k   = int'(ctl.redirect_stage);
    acc = ctl.redirect_req && !frozen && (k < NS) && !st[k];
    fl  = (phase == 2);
    for (int i = 0; i < NS; i++) begin
      bub[i] = (i > 0) && (st[i-1] || (acc && i <= k));
      ev[i]  = (i == 0) ? ctl.in_valid : mv[i];
      ee[i]  = !st[i];
      eb[i]  = bub[i];
    end
    chk("rnd_valid",   ctl.stage_valid,    ev);
    chk("rnd_en",      ctl.stage_en,       ee);
    chk("rnd_bubble",  ctl.stage_bubble,   eb);
    chk("rnd_flush",   ctl.flush_all,      fl);
    chk("rnd_prv",     ctl.pc_redir_valid, m_prv);
    chk("rnd_pcr",     ctl.pc_redir,       m_pcr);
    chk("rnd_pending", ctl.trap_pending,   frozen);
`ifdef PIPE_PERF_CNT_EN
    chk("rnd_cycles",  ctl.perf_cycles,  mc);
    chk("rnd_stalls",  ctl.perf_stalls,  ms);
    chk("rnd_flushes", ctl.perf_flushes, mf);
`else
    chk("rnd_cycles",  ctl.perf_cycles,  0);
`endif
    for (int i = 1; i < NS; i++) begin
      if (fl) mv[i] = 1'b0;
      else if (!st[i]) mv[i] = ev[i-1] && !bub[i];
    end
    if (fl) m_pcr = ctl.trap_pc;
    else if (acc) m_pcr = ctl.redirect_pc;
    m_prv = acc || fl;
    case (phase)
      0: if (ctl.trap_req) phase = ctl.bus_busy ? 1 : 2;
      1: if (!ctl.bus_busy) phase = 2;
      default: phase = 0;
    endcase
    mc = sat_inc(mc);
    if (st[0]) ms = sat_inc(ms);
    if (acc || fl) mf = sat_inc(mf);
    last_acc = acc;
    last_fl  = fl;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vt[22];

  initial begin
    logic [63:0] A, T, T2, R;
    logic        tr_act, rr_act;
    logic [63:0] r_tpc, r_rpc;
    logic [2:0]  r_rs;
    logic [4:0]  r_busy;
    A = 64'h8000_0100; T = 64'h8000_0000; T2 = 64'h8000_0040; R = 64'h1234_5678;

    // Fill, single-cycle stall, redirect, drained trap, trap beats redirect
    vt[0]  = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b00001, 5'b11111, 5'b00000, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[1]  = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b00011, 5'b11111, 5'b00000, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[2]  = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b00111, 5'b11111, 5'b00000, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[3]  = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b01111, 5'b11111, 5'b00000, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[4]  = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b11111, 5'b11111, 5'b00000, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[5]  = mk(5'b00100, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b11111, 5'b11000, 5'b01110, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[6]  = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b10111, 5'b11111, 5'b00000, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[7]  = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b01111, 5'b11111, 5'b00000, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[8]  = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b11111, 5'b11111, 5'b00000, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[9]  = mk(5'b00000, 1'b1, 3'd1, A,     1'b0, 64'h0, 1'b0, 5'b11111, 5'b11111, 5'b00010, 1'b0, 1'b0, 64'h0, 1'b0);
    vt[10] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b11101, 5'b11111, 5'b00000, 1'b0, 1'b1, A,     1'b0);
    vt[11] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b11011, 5'b11111, 5'b00000, 1'b0, 1'b0, A,     1'b0);
    vt[12] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b1, T,     1'b1, 5'b10111, 5'b00000, 5'b11110, 1'b0, 1'b0, A,     1'b1);
    vt[13] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b1, T,     1'b1, 5'b10111, 5'b00000, 5'b11110, 1'b0, 1'b0, A,     1'b1);
    vt[14] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b1, T,     1'b1, 5'b10111, 5'b00000, 5'b11110, 1'b0, 1'b0, A,     1'b1);
    vt[15] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b1, T,     1'b0, 5'b10111, 5'b00000, 5'b11110, 1'b0, 1'b0, A,     1'b1);
    vt[16] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b1, T,     1'b0, 5'b10111, 5'b00000, 5'b11110, 1'b1, 1'b0, A,     1'b1);
    vt[17] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b00001, 5'b11111, 5'b00000, 1'b0, 1'b1, T,     1'b0);
    vt[18] = mk(5'b00000, 1'b1, 3'd2, R,     1'b1, T2,    1'b0, 5'b00011, 5'b00000, 5'b11110, 1'b0, 1'b0, T,     1'b1);
    vt[19] = mk(5'b00000, 1'b1, 3'd2, R,     1'b1, T2,    1'b0, 5'b00011, 5'b00000, 5'b11110, 1'b1, 1'b0, T,     1'b1);
    vt[20] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b00001, 5'b11111, 5'b00000, 1'b0, 1'b1, T2,    1'b0);
    vt[21] = mk(5'b00000, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0, 5'b00011, 5'b11111, 5'b00000, 1'b0, 1'b0, T2,    1'b0);

    drive(1'b0, 5'b0, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",   ctl.stage_valid,    5'b00000);
    chk("rst_flush",   ctl.flush_all,      1'b0);
    chk("rst_prv",     ctl.pc_redir_valid, 1'b0);
    chk("rst_pcr",     ctl.pc_redir,       64'h0);
    chk("rst_pending", ctl.trap_pending,   1'b0);
    chk("rst_cycles",  ctl.perf_cycles,    0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(1'b1, vt[i].busy, vt[i].rr, vt[i].rs, vt[i].rpc, vt[i].tr, vt[i].tpc, vt[i].bb);
      @(negedge clk);
      $display("vec %0d: valid=%b en=%b bub=%b flush=%b prv=%b pcr=%h pend=%b", i,
               ctl.stage_valid, ctl.stage_en, ctl.stage_bubble, ctl.flush_all,
               ctl.pc_redir_valid, ctl.pc_redir, ctl.trap_pending);
      chk($sformatf("vec%0d_valid", i),   ctl.stage_valid,    vt[i].e_valid);
      chk($sformatf("vec%0d_en", i),      ctl.stage_en,       vt[i].e_en);
      chk($sformatf("vec%0d_bubble", i),  ctl.stage_bubble,   vt[i].e_bub);
      chk($sformatf("vec%0d_flush", i),   ctl.flush_all,      vt[i].e_flush);
      chk($sformatf("vec%0d_prv", i),     ctl.pc_redir_valid, vt[i].e_prv);
      chk($sformatf("vec%0d_pcr", i),     ctl.pc_redir,       vt[i].e_pcr);
      chk($sformatf("vec%0d_pending", i), ctl.trap_pending,   vt[i].e_pend);
      @(posedge clk); #1;
    end

    // Reset asserted while draining: everything back to reset values at once
    drive(1'b1, 5'b0, 1'b0, 3'd0, 64'h0, 1'b1, 64'hDEAD_0000, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_en",      ctl.stage_en,     5'b00000);
    chk("drain_pending", ctl.trap_pending, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    ctl.trap_req = 1'b0;
    ctl.bus_busy = 1'b0;
    #1;
    $display("reset-in-drain: valid=%b en=%b flush=%b prv=%b pcr=%h pend=%b",
             ctl.stage_valid, ctl.stage_en, ctl.flush_all, ctl.pc_redir_valid,
             ctl.pc_redir, ctl.trap_pending);
    chk("rdrain_valid",   ctl.stage_valid,    5'b00001);
    chk("rdrain_en",      ctl.stage_en,       5'b11111);
    chk("rdrain_flush",   ctl.flush_all,      1'b0);
    chk("rdrain_prv",     ctl.pc_redir_valid, 1'b0);
    chk("rdrain_pcr",     ctl.pc_redir,       64'h0);
    chk("rdrain_pending", ctl.trap_pending,   1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Ten cycles out of reset: two fetch stalls and one accepted redirect
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, (c == 2 || c == 3) ? 5'b00001 : 5'b00000, (c == 6), 3'd1, 64'hA0,
            1'b0, 64'h0, 1'b0);
      if (c < 3) begin
        @(negedge clk);
        chk($sformatf("postrst%0d_flush", c), ctl.flush_all,      1'b0);
        chk($sformatf("postrst%0d_prv", c),   ctl.pc_redir_valid, 1'b0);
      end
      @(posedge clk); #1;
    end
    $display("perf: cycles=%0d stalls=%0d flushes=%0d pcr=%h",
             ctl.perf_cycles, ctl.perf_stalls, ctl.perf_flushes, ctl.pc_redir);
    chk("perf_pcr", ctl.pc_redir, 64'hA0);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_cycles",  ctl.perf_cycles,  10);
    chk("perf_stalls",  ctl.perf_stalls,  2);
    chk("perf_flushes", ctl.perf_flushes, 1);
`else
    chk("perf_cycles",  ctl.perf_cycles,  0);
    chk("perf_stalls",  ctl.perf_stalls,  0);
    chk("perf_flushes", ctl.perf_flushes, 0);
`endif

    // Randomized run against the model; requesters hold requests until served
    drive(1'b0, 5'b0, 1'b0, 3'd0, 64'h0, 1'b0, 64'h0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    tr_act = 1'b0; rr_act = 1'b0; r_tpc = '0; r_rpc = '0; r_rs = 3'd1;
    for (int c = 0; c < 500; c++) begin
      if (!tr_act && $urandom_range(0, 24) == 0) begin
        tr_act = 1'b1;
        r_tpc  = {$urandom(), $urandom()};
      end
      if (!rr_act && $urandom_range(0, 3) == 0) begin
        rr_act = 1'b1;
        r_rs   = 3'($urandom_range(1, NS - 2));
        r_rpc  = {$urandom(), $urandom()};
      end
      for (int b = 0; b < NS; b++) r_busy[b] = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, r_busy, rr_act, r_rs, r_rpc, tr_act, r_tpc,
            $urandom_range(0, 2) == 0);
      @(negedge clk);
      model_step();
      if (last_acc) rr_act = 1'b0;
      if (last_fl)  tr_act = 1'b0;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
